// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video SRAM between the fixed-latency display fetch
// path (absolute priority) and a CPU req/ack port with a one-entry posted-write buffer.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              wbuf_full,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_PEND,
    RD_DATA,
    RD_CAP,
    ACK
  } cpu_state_t;

  cpu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_data;
  logic              wbuf_load;
  logic              rd_issue;
  logic              rd_cap;
  logic              ack_set;
  logic              drain;

  // The display path samples the SRAM output directly; no extra pipeline stage.
  assign vid_data = sram_rdata;

  // A posted write drains in any cycle the display path leaves free.
  assign drain = wbuf_full && !vid_req;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_nxt = state;
    wbuf_load = 1'b0;
    rd_issue  = 1'b0;
    rd_cap    = 1'b0;
    ack_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            if (!wbuf_full) begin
              wbuf_load = 1'b1;
              ack_set   = 1'b1;
              state_nxt = ACK;
            end
          end else begin
            state_nxt = RD_PEND;
          end
        end
      end
      // Waiting for an empty buffer keeps a read from overtaking an older write.
      RD_PEND: begin
        if (!vid_req && !wbuf_full) begin
          rd_issue  = 1'b1;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: state_nxt = RD_CAP;
      RD_CAP: begin
        rd_cap    = 1'b1;
        ack_set   = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the buffer payload is reset as well as its valid flag; it is only
      // a register pair, and a clean reset value keeps the outputs deterministic.
      wbuf_full  <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_data  <= '0;
      sram_addr  <= '0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_ack <= ack_set;
      sram_we <= 1'b0;

      // One SRAM operation per edge: video, then drain, then CPU read.
      if (vid_req) begin
        sram_addr <= vid_addr;
      end else if (drain) begin
        sram_addr  <= wbuf_addr;
        sram_wdata <= wbuf_data;
        sram_we    <= 1'b1;
      end else if (rd_issue) begin
        sram_addr <= cpu_addr;
      end

      if (wbuf_load) begin
        wbuf_full <= 1'b1;
        wbuf_addr <= cpu_addr;
        wbuf_data <= cpu_wdata;
      end else if (drain) begin
        wbuf_full <= 1'b0;
      end

      if (rd_cap) begin
        cpu_rdata <= sram_rdata;
      end
    end
  end

endmodule
